delay_drain_fifo: RTL and testbench

Elastic buffer downstream of the enable-gated delay lines: captures words leaving a `d_delay_mult` chain and re-presents them on a ready/valid stream. Back-pressure is returned to the delay chain as `stall_o`, which the parent drives into the chain enable as `en_i = ~stall_o`. `Slack` reserves room for words still in flight when the chain freezes. Sits between the delayed datapath of the MNIST layer pipeline and the next handshaking consumer (accumulator / output writer).

---
 rtl/delay_drain_fifo.sv | 115 +++++++++++
 tb/tb_delay_drain_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/delay_drain_fifo.sv
// rtl/delay_drain_fifo.sv - elastic drain buffer behind an enable-gated delay chain
//
// Captures words leaving a delay chain and re-presents them on a ready/valid
// stream. stall_o is decoded from the registered occupancy only, so the parent
// can drive the chain enable (en_i = ~stall_o) without a combinational loop.
// Slack entries stay free when stall_o rises to absorb words still in flight.
//
// Optional feature: define DELAY_DRAIN_FIFO_BYPASS_EN for a zero-latency
// cut-through path when the buffer is empty.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   in_valid_i   input word present
//   in_data_i    input word
//   stall_o      hold request to the upstream delay chain
//   out_valid_o  head word available
//   out_data_o   head word (zero when nothing valid)
//   out_ready_i  consumer accepts head this cycle
//   count_o      occupancy, 0..Depth
//   overflow_o   sticky: an input word was dropped
module delay_drain_fifo #(
  parameter int Bits  = 8,
  parameter int Depth = 4,
  parameter int Slack = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic [Bits-1:0]            in_data_i,
  output logic                       stall_o,
  output logic                       out_valid_o,
  output logic [Bits-1:0]            out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(Depth);
  localparam logic [CW-1:0] STALL_TH_C = CW'(Depth - Slack);

  logic [Bits-1:0] mem [Depth];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic empty;
  logic full;
  logic pop;
  logic pop_mem;
  logic push;
  logic bypass_take;

  always_comb begin
    empty       = (cnt == '0);
    full        = (cnt == DEPTH_C);
    bypass_take = 1'b0;
`ifdef DELAY_DRAIN_FIFO_BYPASS_EN
    // Empty buffer: the input word is the head. If consumed right away it is
    // never written, so pointers and occupancy stay put.
    bypass_take = empty & in_valid_i & out_ready_i;
    out_valid_o = empty ? in_valid_i : 1'b1;
    if (empty) begin
      out_data_o = in_valid_i ? in_data_i : '0;
    end else begin
      out_data_o = mem[rp];
    end
`else
    out_valid_o = ~empty;
    out_data_o  = empty ? '0 : mem[rp];
`endif
    pop     = out_valid_o & out_ready_i;
    pop_mem = pop & ~bypass_take;
    // A pop frees the slot this cycle, so a full buffer still accepts a word.
    push    = in_valid_i & (~full | pop) & ~bypass_take;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem[wp] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop_mem) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop_mem})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (in_valid_i && !push && !bypass_take) begin
        ovf <= 1'b1;
      end
    end
  end

  assign stall_o    = (cnt >= STALL_TH_C);
  assign count_o    = cnt;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_delay_drain_fifo.sv
// tb/tb_delay_drain_fifo.sv - scoreboard bench for delay_drain_fifo
module tb_delay_drain_fifo;

  localparam int Bits  = 8;
  localparam int Depth = 4;
  localparam int Slack = 1;

  logic                  clk = 1'b1;
  logic                  rst_ni;
  logic                  in_valid_i;
  logic [Bits-1:0]       in_data_i;
  logic                  stall_o;
  logic                  out_valid_o;
  logic [Bits-1:0]       out_data_o;
  logic                  out_ready_i;
  logic [$clog2(Depth):0] count_o;
  logic                  overflow_o;

  delay_drain_fifo #(.Bits(Bits), .Depth(Depth), .Slack(Slack)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .stall_o    (stall_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain list of stored words plus a sticky drop flag.
  int  occ      = 0;
  bit  ovf_m    = 0;
  bit  unknown  = 1;
  bit  flush_pending = 0;
  int  cur_cnt  = 0;
  bit  cur_ovf  = 0;
  bit  chk_en   = 0;
  logic [Bits-1:0] sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, records what the model expects to be visible
  // before the coming edge, then advances the model across that edge.
  task automatic do_cycle(input bit rst, input bit vin, input logic [Bits-1:0] d, input bit rdy);
    bit pop;
    bit push;
    if (flush_pending) begin
      sb_q.delete();
      flush_pending = 0;
    end
    rst_ni      = ~rst;
    in_valid_i  = vin;
    in_data_i   = d;
    out_ready_i = rdy;
    chk_en  = ~unknown;
    cur_cnt = occ;
    cur_ovf = ovf_m;
    if (rst) begin
      occ = 0;
      ovf_m = 0;
      unknown = 0;
      flush_pending = 1;
    end else begin
      pop  = (occ > 0) && rdy;
      push = vin && ((occ < Depth) || pop);
      if (push) sb_q.push_back(d);
      if (vin && !push) ovf_m = 1;
      occ = occ + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares everything visible just before the next active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count_o), cur_cnt);
      check("stall", int'(stall_o), int'(cur_cnt >= Depth - Slack));
      check("overflow", int'(overflow_o), int'(cur_ovf));
      check("out_valid", int'(out_valid_o), int'(cur_cnt != 0));
      if (out_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("out_data", int'(out_data_o), int'(sb_q[0]));
          if (out_ready_i === 1'b1 && rst_ni === 1'b1) void'(sb_q.pop_front());
        end
      end else begin
        check("out_data_idle", int'(out_data_o), 0);
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    out_ready_i = 1'b0;

    // reset with input asserted
    do_cycle(1, 1, 8'hEE, 0);
    do_cycle(1, 1, 8'hEE, 0);
    // fill
    do_cycle(0, 1, 8'h11, 0);
    do_cycle(0, 1, 8'h22, 0);
    do_cycle(0, 1, 8'h33, 0);
    do_cycle(0, 1, 8'h44, 0);
    // overflow, then hold to see it persist
    do_cycle(0, 1, 8'h55, 0);
    do_cycle(0, 0, 8'h00, 0);
    // full with simultaneous push and pop
    do_cycle(0, 1, 8'h66, 1);
    // drain
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 8'h00, 1);
    // wrap-around with toggling ready
    for (int i = 0; i < 16; i++) do_cycle(0, 1, 8'(i), (i % 2) == 0);
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 8'h00, (i % 2) == 0);
    // empty buffer, word with ready high: visible one cycle later
    do_cycle(1, 0, 8'h00, 0);
    do_cycle(0, 1, 8'hA5, 1);
    do_cycle(0, 0, 8'h00, 1);
    do_cycle(0, 0, 8'h00, 1);
    // randomized traffic with occasional resets and ready droughts
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit v;
      bit rd;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ((i / 64) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      do_cycle(r, v, 8'($urandom), rd);
    end
    do_cycle(0, 0, 8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
